// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types, constants and frame helpers for the LED pattern sequencer.
package led_pattern_sequencer_pkg;

  localparam int unsigned FrameWidth = 8;
  localparam int unsigned TimerWidth = 24;

  typedef logic [FrameWidth-1:0] frame_t;

  typedef enum logic [1:0] {
    ModeCount  = 2'd0,
    ModeGray   = 2'd1,
    ModeWalk   = 2'd2,
    ModeBounce = 2'd3
  } mode_e;

  typedef enum logic {
    StEmpty,
    StFull
  } hs_state_e;

  localparam frame_t SeedCount  = 8'h00;
  localparam frame_t SeedGray   = 8'h00;
  localparam frame_t SeedWalk   = 8'h01;
  localparam frame_t SeedBounce = 8'h01;

  function automatic frame_t seed_of(mode_e mode);
    frame_t seed;
    unique case (mode)
      ModeCount:  seed = SeedCount;
      ModeGray:   seed = SeedGray;
      ModeWalk:   seed = SeedWalk;
      ModeBounce: seed = SeedBounce;
    endcase
    return seed;
  endfunction

  // Only Gray mode encodes the pattern register; the others show it directly.
  function automatic frame_t frame_of(mode_e mode, frame_t p);
    return (mode == ModeGray) ? (p ^ (p >> 1)) : p;
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus stability counter; pulses once per accepted rising level.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise_pulse
);

  localparam int unsigned CntWidth = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          r_sync;
  logic                r_level;
  logic                r_rise;
  logic [CntWidth-1:0] r_cnt;
  logic                w_differ;
  logic                w_flip;

  assign w_differ = r_sync[1] ^ r_level;
  // Level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  assign w_flip   = w_differ && (r_cnt == CntMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_rise <= w_flip && r_sync[1];
      if (w_flip) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level      = r_level;
  assign o_rise_pulse = r_rise;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Frame timer, pattern generator and valid/ready frame register feeding the LED serialiser.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int unsigned UPDATE_MS   = 200,
  parameter int unsigned MS_CYCLES   = 12000,
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_btn,
  input  logic                  i_pause,
  output logic [FrameWidth-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [1:0]            o_mode,
  output logic                  o_overrun
);

  localparam logic [TimerWidth-1:0] TimerMax = TimerWidth'(UPDATE_MS * MS_CYCLES - 1);

  logic [TimerWidth-1:0] r_tmr;
  hs_state_e             r_state;
  hs_state_e             w_state_d;
  mode_e                 r_mode;
  mode_e                 w_mode_next;
  frame_t                r_pat;
  frame_t                r_data;
  frame_t                w_pat_adv;
  frame_t                w_pat_emit;
  logic                  r_dir_down;
  logic                  w_dir_adv;
  logic                  r_seed_pend;
  logic                  r_overrun;
  logic                  w_tick;
  logic                  w_emit;
  logic                  w_btn_level;
  logic                  w_btn_rise;
  logic                  w_mode_step;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_MS * MS_CYCLES)
  ) u_btn_debouncer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_btn        (i_btn),
    .o_level      (w_btn_level),
    .o_rise_pulse (w_btn_rise)
  );

  assign w_mode_step = w_btn_rise && w_btn_level;
  assign w_mode_next = mode_e'(r_mode + 2'd1);
  assign w_tick      = !i_pause && (r_tmr == TimerMax);
  // A mode step swallows a coincident tick; a tick with a frame pending is dropped.
  assign w_emit      = w_tick && !w_mode_step && (r_state == StEmpty);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tmr <= '0;
    end else if (w_mode_step || w_tick) begin
      r_tmr <= '0;
    end else if (!i_pause) begin
      r_tmr <= r_tmr + TimerWidth'(1);
    end
  end

  always_comb begin
    w_pat_adv = r_pat;
    w_dir_adv = r_dir_down;
    unique case (r_mode)
      ModeCount, ModeGray: w_pat_adv = r_pat + 8'd1;
      ModeWalk:            w_pat_adv = {r_pat[6:0], r_pat[7]};
      ModeBounce: begin
        if (!r_dir_down) begin
          w_pat_adv = r_pat << 1;
          if (w_pat_adv == 8'h80) w_dir_adv = 1'b1;
        end else begin
          w_pat_adv = r_pat >> 1;
          if (w_pat_adv == 8'h01) w_dir_adv = 1'b0;
        end
      end
    endcase
  end

  assign w_pat_emit = r_seed_pend ? r_pat : w_pat_adv;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode      <= ModeCount;
      r_pat       <= SeedCount;
      r_dir_down  <= 1'b0;
      r_seed_pend <= 1'b1;
      r_data      <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_mode_step) begin
        r_mode      <= w_mode_next;
        r_pat       <= seed_of(w_mode_next);
        r_dir_down  <= 1'b0;
        r_seed_pend <= 1'b1;
      end else if (w_emit) begin
        r_pat       <= w_pat_emit;
        r_data      <= frame_of(r_mode, w_pat_emit);
        r_seed_pend <= 1'b0;
        if (!r_seed_pend) r_dir_down <= w_dir_adv;
      end
      if (w_tick && !w_mode_step && (r_state == StFull)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StEmpty: if (w_emit) w_state_d = StFull;
      StFull:  if (i_ready) w_state_d = StEmpty;
    endcase
  end

  always_comb begin
    o_valid   = (r_state == StFull);
    o_data    = r_data;
    o_mode    = r_mode;
    o_overrun = r_overrun;
  end

endmodule
